modem_tx_sched: RTL and testbench
=================================

Name: modem_tx_sched

Overview:
- Scheduler between the COBS-encoded TX byte stream (output of the eth->modem clock-crossing FIFO) and the modem TX AXI-Stream input, in the iclk_h domain.
- Paces bytes to a programmable modem byte rate using a credit bucket.
- Fills idle link time with 0x00 COBS delimiters.
- Pauses only at frame boundaries when the far end is congested.
- Aborts frames whose source stalls mid-frame by injecting a delimiter, then discards the rest of that frame.

Parameters:
- IDLE_FILL, 1: 1 = emit 0x00 fill bytes when no frame byte is issued; 0 = m_axis_tvalid stays low when idle.
- STALL_TIMEOUT, 4096: source-starved cycles inside a frame before abort, range 2..65535.
- CREDIT_MAX, 8: saturation value of the byte credit counter, range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- iclk_h  in  1  modem-side clock; everything is synchronous to it.
- irst_h  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  COBS byte stream from the clock-crossing FIFO; 0x00 = frame delimiter.
- s_axis_tvalid  in  1  source byte valid.
- s_axis_tready  out  1  source byte accept.
- m_axis_tdata  out  8  byte to the modem TX.
- m_axis_tvalid  out  1  byte valid to the modem.
- m_axis_tready  in  1  modem accept.
- ienable  in  1  start new frames / fill; synchronous level.
- ipause  in  1  far-end congestion (RX FIFO prog_full); asynchronous, passed through a 2-flop synchronizer to pause_s.
- irate_inc  in  16  phase increment per cycle; 0 = unpaced (credit ignored).
- oframes_sent  out  CNT_W  count of frames completed normally; wraps.
- oframes_aborted  out  CNT_W  count of frames aborted on stall; wraps.
- ostate  out  2  0 IDLE, 1 FRAME, 2 ABORT, 3 DISCARD.
- oin_frame  out  1  high when state is FRAME.

Behaviour:
- Reset (irst_h low, async): state IDLE, holding register empty, all outputs 0, credit 0, phase 0, stall counter 0, sync flops 0.
- Output stage:
  - One holding register drives m_axis_tdata/m_axis_tvalid.
  - tdata is stable while tvalid=1 and tready=0.
  - slot_free = !m_axis_tvalid || m_axis_tready.
  - Latency: a source byte accepted in cycle N is presented on m_axis in cycle N+1.
- Pacing:
  - Each cycle: {carry, phase} = phase + irate_inc; carry increments credit, saturating at CREDIT_MAX.
  - can_issue = slot_free && (irate_inc==0 || credit!=0).
  - Every byte loaded into the holding register (data, fill or abort) consumes 1 credit when paced.
  - Carry and consume in the same cycle: credit unchanged.
  - Credit never underflows.
- IDLE:
  - s_axis_tready = can_issue && ienable && !pause_s.
  - Accepted byte is forwarded. Non-zero byte -> FRAME with stall counter cleared. 0x00 -> stays IDLE, not counted as a frame.
  - If no byte is accepted and IDLE_FILL && ienable && can_issue: load 0x00 fill.
  - Fill continues while paused.
- FRAME:
  - s_axis_tready = can_issue; pause_s and ienable are ignored (frame-aligned).
  - Accepted non-zero byte is forwarded and clears the stall counter.
  - Accepted 0x00 is forwarded, oframes_sent++, -> IDLE.
  - Stall counter increments on cycles with s_axis_tvalid=0 and holds during credit or m_axis backpressure.
  - When the counter reaches STALL_TIMEOUT-1, the next cycle is ABORT.
- ABORT:
  - s_axis_tready=0.
  - On can_issue: load 0x00, oframes_aborted++, -> DISCARD.
- DISCARD:
  - s_axis_tready=1; accepted bytes are dropped and consume no credit.
  - Accepted 0x00 -> IDLE.
  - Fill bytes are generated as in IDLE.
- No fill byte is ever inserted while in FRAME; frame bytes are never reordered.
- ostate and oin_frame are registered state, updated in the same cycle as the transition.

Decomposition:
- Shared package modem_tx_pkg: state encoding constants (ST_IDLE..ST_DISCARD), COBS_DELIM = 8'h00.
- Natural sub-module: modem_tx_credit (phase accumulator plus saturating credit counter; inputs irate_inc and consume, output credit_ok).
- The synchronizer and FSM stay in the top module.

Test Plan:
- Unpaced (irate_inc=0), tready=1, frame 03 11 22 00 -> m_axis shows 03 11 22 00 one cycle after each accept; oframes_sent=1; IDLE_FILL=1 gives 00 on all other cycles.
- Pacing: irate_inc=0x4000, source always valid -> exactly 1 byte per 4 cycles on m_axis over 400 cycles (100±1 bytes); credit never exceeds CREDIT_MAX.
- Pause: ipause set after byte 2 of a 6-byte frame -> frame completes including 00; no new frame starts while pause_s=1; frame starts 3 cycles after ipause drops (2 sync + 1).
- Stall: STALL_TIMEOUT=16, source sends 05 AA then stops -> after 16 starved cycles m_axis emits 00, oframes_aborted=1; later bytes BB CC 00 are dropped; the next frame is forwarded intact.
- Backpressure: m_axis_tready=0 for 100 cycles mid-frame -> tdata stable, no abort, no data loss.
- Reset mid-frame: irst_h pulsed low -> m_axis_tvalid=0 immediately (async), state IDLE, counters 0.

Source files
------------

// File: rtl/modem_tx_pkg.sv
// Shared types and constants for the modem TX scheduler.
package modem_tx_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned RATE_W   = 16;
    localparam int unsigned STALL_W  = 16;
    localparam int unsigned CREDIT_W = 8;

    localparam logic [BYTE_W-1:0] COBS_DELIM = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME   = 2'd1,
        ST_ABORT   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    // Output holding register payload
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              valid;
    } tx_byte_t;

endpackage

// File: rtl/modem_tx_credit.sv
// Phase accumulator feeding a saturating byte-credit bucket.
module modem_tx_credit
    import modem_tx_pkg::*;
#(
    parameter int unsigned CREDIT_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RATE_W-1:0] irate_inc,
    input  logic              consume,
    output logic              credit_ok
);

    logic [RATE_W-1:0]   phase_q;
    logic [RATE_W:0]     phase_sum;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic                carry;
    logic                paced;
    logic                take;

    assign phase_sum = {1'b0, phase_q} + {1'b0, irate_inc};
    assign carry     = phase_sum[RATE_W];
    assign paced     = (irate_inc != '0);
    // Consumption is ignored when unpaced and can never go below zero
    assign take      = consume && paced && (credit_q != '0);
    assign credit_ok = !paced || (credit_q != '0);

    always_comb begin
        credit_d = credit_q;
        if (carry && !take) begin
            if (credit_q >= CREDIT_W'(CREDIT_MAX)) begin
                credit_d = CREDIT_W'(CREDIT_MAX);
            end else begin
                credit_d = credit_q + CREDIT_W'(1);
            end
        end else if (!carry && take) begin
            credit_d = credit_q - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            credit_q <= '0;
        end else begin
            phase_q  <= phase_sum[RATE_W-1:0];
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/modem_tx_sched.sv
// Paces COBS frame bytes onto the modem TX stream, fills idle time with
// delimiters, pauses at frame boundaries and aborts stalled frames.
module modem_tx_sched
    import modem_tx_pkg::*;
#(
    parameter int unsigned IDLE_FILL     = 1,
    parameter int unsigned STALL_TIMEOUT = 4096,
    parameter int unsigned CREDIT_MAX    = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              iclk_h,
    input  logic              irst_h,
    input  logic [BYTE_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [BYTE_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              ienable,
    input  logic              ipause,
    input  logic [RATE_W-1:0] irate_inc,
    output logic [CNT_W-1:0]  oframes_sent,
    output logic [CNT_W-1:0]  oframes_aborted,
    output logic [1:0]        ostate,
    output logic              oin_frame
);

    localparam bit               FILL_EN   = (IDLE_FILL != 0);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

    state_t              state_q;
    state_t              state_d;
    tx_byte_t            hold_q;
    logic                pause_meta;
    logic                pause_s;
    logic [STALL_W-1:0]  stall_q;
    logic [CNT_W-1:0]    sent_q;
    logic [CNT_W-1:0]    aborted_q;

    logic                credit_ok;
    logic                slot_free;
    logic                can_issue;
    logic                fill_ok;
    logic                s_ready;
    logic                accept;
    logic                is_delim;
    logic                load;
    logic [BYTE_W-1:0]   load_byte;
    logic                sent_inc;
    logic                abort_inc;
    logic                stall_clr;
    logic                stall_inc;

    // Far-end congestion arrives asynchronously
    always_ff @(posedge iclk_h or negedge irst_h) begin
        if (!irst_h) begin
            pause_meta <= 1'b0;
            pause_s    <= 1'b0;
        end else begin
            pause_meta <= ipause;
            pause_s    <= pause_meta;
        end
    end

    modem_tx_credit #(
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit (
        .clk       (iclk_h),
        .rst_n     (irst_h),
        .irate_inc (irate_inc),
        .consume   (load),
        .credit_ok (credit_ok)
    );

    assign slot_free = !hold_q.valid || m_axis_tready;
    assign can_issue = slot_free && credit_ok;
    assign fill_ok   = FILL_EN && ienable && can_issue;
    assign accept    = s_axis_tvalid && s_ready;
    assign is_delim  = (s_axis_tdata == COBS_DELIM);

    always_ff @(posedge iclk_h or negedge irst_h) begin
        if (!irst_h) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !is_delim) begin
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (accept && is_delim) begin
                    state_d = ST_IDLE;
                end else if (!s_axis_tvalid && (stall_q == STALL_LAST)) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (can_issue) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (accept && is_delim) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state handshake, holding-register load and bookkeeping strobes
    always_comb begin
        s_ready   = 1'b0;
        load      = 1'b0;
        load_byte = COBS_DELIM;
        sent_inc  = 1'b0;
        abort_inc = 1'b0;
        stall_clr = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = can_issue && ienable && !pause_s;
                if (s_axis_tvalid && s_ready) begin
                    load      = 1'b1;
                    load_byte = s_axis_tdata;
                    stall_clr = 1'b1;
                end else if (fill_ok) begin
                    load = 1'b1;
                end
            end
            ST_FRAME: begin
                s_ready = can_issue;
                if (s_axis_tvalid && s_ready) begin
                    load      = 1'b1;
                    load_byte = s_axis_tdata;
                    stall_clr = 1'b1;
                    sent_inc  = is_delim;
                end else if (!s_axis_tvalid) begin
                    stall_inc = 1'b1;
                end
            end
            ST_ABORT: begin
                if (can_issue) begin
                    load      = 1'b1;
                    abort_inc = 1'b1;
                end
            end
            ST_DISCARD: begin
                s_ready = 1'b1;
                load    = fill_ok;
            end
            default: ;
        endcase
    end

    assign s_axis_tready = s_ready;

    // Holding register: data stays put until the modem takes it
    always_ff @(posedge iclk_h or negedge irst_h) begin
        if (!irst_h) begin
            hold_q <= '0;
        end else if (load) begin
            hold_q.data  <= load_byte;
            hold_q.valid <= 1'b1;
        end else if (m_axis_tready) begin
            hold_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge iclk_h or negedge irst_h) begin
        if (!irst_h) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != STALL_LAST)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge iclk_h or negedge irst_h) begin
        if (!irst_h) begin
            sent_q    <= '0;
            aborted_q <= '0;
        end else begin
            if (sent_inc) begin
                sent_q <= sent_q + CNT_W'(1);
            end
            if (abort_inc) begin
                aborted_q <= aborted_q + CNT_W'(1);
            end
        end
    end

    assign m_axis_tdata    = hold_q.data;
    assign m_axis_tvalid   = hold_q.valid;
    assign oframes_sent    = sent_q;
    assign oframes_aborted = aborted_q;
    assign ostate          = state_q;
    assign oin_frame       = (state_q == ST_FRAME);

endmodule

// File: tb/tb_modem_tx_sched.sv
// Directed self-checking bench for modem_tx_sched (STALL_TIMEOUT=16).
module tb_modem_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        ienable;
    logic        ipause;
    logic [15:0] rate;
    logic [15:0] frames_sent;
    logic [15:0] frames_aborted;
    logic [1:0]  state;
    logic        in_frame;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    int max_credit = 0;
    logic [7:0] mon_q[$];

    always #5 clk = ~clk;

    modem_tx_sched #(
        .IDLE_FILL     (1),
        .STALL_TIMEOUT (16),
        .CREDIT_MAX    (8),
        .CNT_W         (16)
    ) dut (
        .iclk_h          (clk),
        .irst_h          (rst_n),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .ienable         (ienable),
        .ipause          (ipause),
        .irate_inc       (rate),
        .oframes_sent    (frames_sent),
        .oframes_aborted (frames_aborted),
        .ostate          (state),
        .oin_frame       (in_frame)
    );

    // Inputs change at posedge+1, so the negedge view is what the next edge transfers
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            mon_q.push_back(m_tdata);
            xfer_cnt++;
        end
        if (int'(dut.u_credit.credit_q) > max_credit) begin
            max_credit = int'(dut.u_credit.credit_q);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a byte valid until accepted; returns at posedge+1 after the accepting edge
    task automatic send_byte(input string tag, input logic [7:0] b);
        bit acc;
        bit ok;
        ok = 1'b0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            acc = s_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        s_tvalid = 1'b0;
        check({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    // Sends a byte and checks it is on m_axis in the following cycle
    task automatic send_fwd(input string tag, input logic [7:0] b);
        send_byte(tag, b);
        check({tag, "_data"}, {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, b});
    endtask

    initial begin
        bit         stable;
        logic [7:0] got [4];

        rst_n    = 1'b0;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        ienable  = 1'b0;
        ipause   = 1'b0;
        rate     = 16'd0;
        repeat (3) tick();
        check("reset_outputs", {in_frame, state, m_tvalid, s_tready}, 32'd0);
        check("reset_counters", {frames_sent, frames_aborted}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("disabled_no_fill", 32'(m_tvalid), 32'd0);

        // Unpaced frame with idle fill around it
        ienable = 1'b1;
        tick();
        tick();
        check("idle_fill", {m_tvalid, m_tdata}, {1'b1, 8'h00});
        send_fwd("f1_b0", 8'h03);
        check("f1_in_frame", {state, in_frame}, {2'd1, 1'b1});
        send_fwd("f1_b1", 8'h11);
        send_fwd("f1_b2", 8'h22);
        send_fwd("f1_b3", 8'h00);
        check("f1_sent", 32'(frames_sent), 32'd1);
        check("f1_idle", {state, in_frame}, {2'd0, 1'b0});
        tick();
        check("f1_fill_after", {m_tvalid, m_tdata}, {1'b1, 8'h00});

        // Paced at one byte per four cycles
        xfer_cnt = 0;
        rate     = 16'h4000;
        s_tdata  = 8'h55;
        s_tvalid = 1'b1;
        repeat (400) tick();
        check("pace_rate", 32'((xfer_cnt >= 99) && (xfer_cnt <= 101)), 32'd1);
        check("pace_in_frame", 32'(state), 32'd1);
        send_byte("pace_end", 8'h00);
        check("pace_sent", 32'(frames_sent), 32'd2);
        ienable = 1'b0;
        repeat (60) tick();
        check("credit_saturated", 32'(dut.u_credit.credit_q), 32'd8);
        check("credit_max_seen", 32'(max_credit <= 8), 32'd1);
        rate    = 16'd0;
        ienable = 1'b1;
        repeat (3) tick();

        // Pause raised mid-frame: frame still completes
        send_fwd("p_b0", 8'h01);
        send_fwd("p_b1", 8'h02);
        ipause = 1'b1;
        send_fwd("p_b2", 8'h03);
        send_fwd("p_b3", 8'h04);
        send_fwd("p_b4", 8'h05);
        send_fwd("p_b5", 8'h00);
        check("p_sent", 32'(frames_sent), 32'd3);
        s_tdata  = 8'h07;
        s_tvalid = 1'b1;
        repeat (10) tick();
        check("p_held_idle", {state, m_tvalid, m_tdata}, {2'd0, 1'b1, 8'h00});
        ipause = 1'b0;
        tick();
        check("p_release_e1", 32'(state), 32'd0);
        tick();
        check("p_release_e2", 32'(state), 32'd0);
        tick();
        check("p_release_e3", {state, m_tdata}, {2'd1, 8'h07});
        send_byte("p_end", 8'h00);
        check("p_sent2", 32'(frames_sent), 32'd4);

        // Source stalls mid-frame: abort after 16 starved cycles
        send_fwd("s_b0", 8'h05);
        send_fwd("s_b1", 8'hAA);
        repeat (15) tick();
        check("s_still_frame", {state, m_tvalid}, {2'd1, 1'b0});
        tick();
        check("s_abort_state", {state, frames_aborted}, {2'd2, 16'd0});
        tick();
        check("s_abort_delim", {state, m_tvalid, m_tdata}, {2'd3, 1'b1, 8'h00});
        check("s_aborted", 32'(frames_aborted), 32'd1);
        send_byte("s_drop0", 8'hBB);
        check("s_drop0_fill", {state, m_tdata}, {2'd3, 8'h00});
        send_byte("s_drop1", 8'hCC);
        check("s_drop1_fill", {state, m_tdata}, {2'd3, 8'h00});
        send_byte("s_drop2", 8'h00);
        check("s_back_idle", {state, frames_sent}, {2'd0, 16'd4});
        send_fwd("s_n0", 8'h09);
        send_fwd("s_n1", 8'h0A);
        send_fwd("s_n2", 8'h00);
        check("s_next_sent", {frames_sent, frames_aborted}, {16'd5, 16'd1});

        // Modem backpressure mid-frame
        send_fwd("bp_b0", 8'h31);
        mon_q.delete();
        m_tready = 1'b0;
        s_tdata  = 8'h32;
        s_tvalid = 1'b1;
        stable   = 1'b1;
        repeat (100) begin
            tick();
            if (m_tdata !== 8'h31 || m_tvalid !== 1'b1 || state !== 2'd1) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        m_tready = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check("bp_resume", {m_tvalid, m_tdata}, {1'b1, 8'h32});
        send_fwd("bp_b2", 8'h33);
        send_fwd("bp_b3", 8'h00);
        tick();
        for (int i = 0; i < 4; i++) got[i] = (mon_q.size() > i) ? mon_q[i] : 8'hEE;
        check("bp_stream", {got[0], got[1], got[2], got[3]}, 32'h31323300);
        check("bp_sent", {frames_sent, frames_aborted}, {16'd6, 16'd1});

        // Asynchronous reset mid-frame
        send_fwd("r_b0", 8'h41);
        rst_n = 1'b0;
        #1;
        check("r_async", {m_tvalid, state, in_frame}, 32'd0);
        check("r_counters", {frames_sent, frames_aborted}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        send_fwd("r_n0", 8'h42);
        send_fwd("r_n1", 8'h00);
        check("r_sent", {frames_sent, frames_aborted}, {16'd1, 16'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
